seg_scan: RTL and testbench
===========================

// Module: seg_scan
// PURPOSE
//  Time-multiplexed scanner for the 8-digit 7-segment display.
//  - Holds an 8-nibble value and drives one digit at a time.
//  - nib feeds the 4-bit input of the downstream 7-seg decoder; dig drives the digit enables.
//  - New values are double-buffered and only take effect at a frame boundary, so no frame shows torn data.
//  - A blanking gap between digits suppresses ghosting.
// PARAMETERS
//  NDIG     8      number of digits scanned (dig width, data_in width = 4*NDIG)
//  CLK_DIV  50000  clk cycles per digit slot (>=2)
//  BLANK    16     cycles at start of each slot with all digits off (0..CLK_DIV-1)
// PORTS
//  clk        in   1       system clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  data_in    in   4*NDIG  value to display; nibble k -> digit k, digit 0 rightmost
//  load       in   1       1-cycle strobe: capture data_in into staging register
//  lzb        in   1       1 = blank leading zero digits
//  nib        out  4       code for decoder; 4'hF = blank (decoder drives all segments off)
//  dig        out  NDIG    digit enables, active-low, at most one bit low
//  pending    out  1       staged value not yet shown
//  frame_done out  1       1-cycle pulse on the last cycle of each frame
// BEHAVIOUR
//  Reset (async, rst_n=0):
//  - cnt=0, idx=0, shadow=0, staged=0, pending=0.
//  - dig=all ones, nib=4'hF, frame_done=0.
//  - All take effect immediately, mid-slot included.
//  Slot counter:
//  - cnt counts 0..CLK_DIV-1 and wraps.
//  - At cnt==CLK_DIV-1, idx increments, wrapping NDIG-1 -> 0.
//  - Frame = NDIG*CLK_DIV cycles.
//  Per-slot states:
//  - BLANK while cnt<BLANK: dig=all ones, nib=4'hF.
//  - ON while cnt>=BLANK: dig=~(1<<idx), nib=shadow[4*idx+3:4*idx], or 4'hF if blanked.
//  - BLANK=0 gives no blank state.
//  Output registering:
//  - dig and nib are registered from the current cnt/idx: 1 clk latency.
//  - First ON output appears the cycle after cnt reaches BLANK.
//  - Last slot output holds through the first cycle of the next slot.
//  Frame boundary (cnt==CLK_DIV-1 && idx==NDIG-1):
//  - frame_done=1 for that cycle (registered, so visible the next cycle).
//  - If pending: shadow<=staged, pending<=0.
//  Load:
//  - On load=1, staged<=data_in and pending<=1.
//  - Repeated loads within a frame overwrite staged; the last one wins.
//  - load coincident with boundary: shadow<=data_in directly, pending stays 0.
//  - Data is never lost or delayed an extra frame.
//  Leading-zero blanking (lzb=1):
//  - Digit k is blanked if shadow nibbles k..NDIG-1 are all 0 and k!=0.
//  - Digit 0 always shows, so value 0 displays "0".
//  - lzb is sampled live each cycle.
//  Nibble values:
//  - Nibbles A..E pass through unchanged.
//  - Nibble F is indistinguishable from blank by design.
// TESTING (NDIG=8, CLK_DIV=8, BLANK=2)
//  1 Reset low mid-slot:
//    - dig=8'hFF, nib=F, pending=0 with no clock edge.
//    - After release, first ON shows digit 0 with nib=0.
//  2 load 32'h12345678:
//    - pending=1 until boundary; next frame slots 0..7 give nib=8,7,..,1 with dig=FE,FD,..,7F.
//    - Each slot shows dig=FF for 2 cycles, then 6 cycles ON.
//  3 lzb=1, value 32'h00000450:
//    - Digits 0..2 show 0,5,4; digits 3..7 give nib=F.
//    - Value 0 shows only digit 0 = 0.
//  4 Two loads (AAAA0001, then 00000002) in one frame:
//    - Next frame shows ...0002; frame_done pulses once per 64 cycles.
//  5 load 32'h87654321 on the boundary cycle:
//    - Next frame shows it; pending never asserts.
//  6 Check every cycle: never more than one dig bit low.

Source files
------------

// File: rtl/seg_scan.sv
// seg_scan: time-multiplexed 7-segment scanner with frame-synchronous double buffering
module seg_scan #(
    parameter int NDIG    = 8,
    parameter int CLK_DIV = 50000,
    parameter int BLANK   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4*NDIG-1:0] data_in,
    input  logic              load,
    input  logic              lzb,
    output logic [3:0]        nib,
    output logic [NDIG-1:0]   dig,
    output logic              pending,
    output logic              frame_done
);
    localparam int CW = $clog2(CLK_DIV);
    localparam int IW = NDIG > 1 ? $clog2(NDIG) : 1;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [4*NDIG-1:0] shadow_q, shadow_d, staged_q, staged_d;
    logic              pending_q, pending_d, frame_done_q, frame_done_d;
    logic [NDIG-1:0]   dig_q, dig_d;
    logic [3:0]        nib_q, nib_d;
    logic [3:0]        nibs [NDIG];
    logic [NDIG-1:0]   lz;
    logic              last_cnt, boundary, on;
    // lz[g]: this digit and every digit above it are zero, so it is a leading zero
    for (genvar g = 0; g < NDIG; g++) begin : g_dig
        assign nibs[g] = shadow_q[4*g +: 4];
        assign lz[g]   = (g != 0) && (shadow_q[4*NDIG-1:4*g] == '0);
    end
    always_comb begin
        last_cnt     = cnt_q == CW'(CLK_DIV - 1);
        boundary     = last_cnt && idx_q == IW'(NDIG - 1);
        cnt_d        = last_cnt ? '0 : cnt_q + 1'b1;
        idx_d        = last_cnt ? (boundary ? '0 : idx_q + 1'b1) : idx_q;
        shadow_d     = shadow_q;
        staged_d     = staged_q;
        pending_d    = pending_q;
        if (boundary) begin
            shadow_d  = load ? data_in : pending_q ? staged_q : shadow_q;
            pending_d = 1'b0;
        end else if (load) begin
            staged_d  = data_in;
            pending_d = 1'b1;
        end
        on           = cnt_q >= CW'(BLANK);
        dig_d        = on ? ~(NDIG'(1) << idx_q) : '1;
        nib_d        = (on && !(lzb && lz[idx_q])) ? nibs[idx_q] : 4'hF;
        frame_done_d = boundary;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            shadow_q     <= '0;
            staged_q     <= '0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
            dig_q        <= '1;
            nib_q        <= 4'hF;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            staged_q     <= staged_d;
            pending_q    <= pending_d;
            frame_done_q <= frame_done_d;
            dig_q        <= dig_d;
            nib_q        <= nib_d;
        end
    end
    assign nib        = nib_q;
    assign dig        = dig_q;
    assign pending    = pending_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: directed and random checks of seg_scan against a frame-position reference model
module tb_seg_scan;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] data_in = '0;
    logic        load = 1'b0;
    logic        lzb = 1'b0;
    logic [3:0]  nib;
    logic [7:0]  dig;
    logic        pending, frame_done;
    int          tests = 0;
    int          fails = 0;
    int          t = 0;
    logic [31:0] m_sh = '0;
    logic [31:0] m_st = '0;
    logic        m_pend = 1'b0;

    seg_scan #(.NDIG(8), .CLK_DIV(8), .BLANK(2)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .load(load), .lzb(lzb),
        .nib(nib), .dig(dig), .pending(pending), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
        end
    endtask

    // One clock of the reference: a frame is 64 cycles, 8 slots of 8, first 2 of each blank
    task automatic tick();
        int p = t % 64;
        int s = p / 8;
        int c = p % 8;
        logic [31:0] hi = m_sh >> (4 * s);
        logic [7:0]  ed = (c < 2) ? 8'hFF : ~(8'd1 << s);
        logic [3:0]  en = (c < 2 || (lzb && s != 0 && hi == 0)) ? 4'hF : hi[3:0];
        logic        efd = (p == 63);
        if (p == 63) begin
            if (load) m_sh = data_in;
            else if (m_pend) m_sh = m_st;
            m_pend = 1'b0;
        end else if (load) begin
            m_st   = data_in;
            m_pend = 1'b1;
        end
        t++;
        @(posedge clk);
        #1;
        chk("dig", 32'(dig), 32'(ed));
        chk("nib", 32'(nib), 32'(en));
        chk("frame_done", 32'(frame_done), 32'(efd));
        chk("pending", 32'(pending), 32'(m_pend));
        chk("onehot", 32'($countones(~dig) <= 1), 32'd1);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_load(input logic [31:0] v);
        data_in = v;
        load    = 1'b1;
        tick();
        load    = 1'b0;
        data_in = $urandom;
    endtask

    task automatic to_boundary();
        while (t % 64 != 63) tick();
    endtask

    task automatic check_reset();
        chk("rst_dig", 32'(dig), 32'hFF);
        chk("rst_nib", 32'(nib), 32'hF);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
    endtask

    initial begin
        #12;
        check_reset();
        rst_n = 1'b1;
        run(70);
        do_load(32'h12345678);
        run(140);
        lzb = 1'b1;
        do_load(32'h00000450);
        run(140);
        do_load(32'h00000000);
        run(140);
        lzb = 1'b0;
        run(5);
        do_load(32'hAAAA0001);
        run(20);
        do_load(32'h00000002);
        run(140);
        to_boundary();
        do_load(32'h87654321);
        run(140);
        do_load(32'hFEDCBA90);
        run(20);
        to_boundary();
        do_load(32'h0000ABCD);
        run(70);
        for (int i = 0; i < 2000; i++) begin
            lzb = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) do_load($urandom & ($urandom_range(0, 1) ? 32'hFFFFFFFF : 32'h0000FFFF));
            else tick();
        end
        // asynchronous reset in the middle of an ON slot, no clock edge in between
        do_load(32'h11111111);
        while (t % 8 != 4) tick();
        rst_n = 1'b0;
        #1;
        check_reset();
        @(posedge clk);
        #1;
        check_reset();
        rst_n = 1'b1;
        t = 0;
        m_sh = '0;
        m_st = '0;
        m_pend = 1'b0;
        run(140);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
